// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, receiver FSM states and the baud counter width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_t;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } rx_state_t;

    function automatic int unsigned baud_cnt_w(input int unsigned clk_div);
        return (clk_div < 2) ? 1 : $clog2(clk_div);
    endfunction

endpackage

// File: rtl/uart_rx_baudgen.sv
// Bit-period tick generator: a rising en preloads half a period so ticks land mid-bit.
module uart_rx_baudgen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned BAUD_CNT_W = baud_cnt_w(CLK_DIV);
    localparam logic [BAUD_CNT_W-1:0] HalfLoad = BAUD_CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [BAUD_CNT_W-1:0] FullLoad = BAUD_CNT_W'(CLK_DIV - 1);

    logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;
    logic                  en_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && !en_q) begin
            cnt_d = HalfLoad;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? FullLoad : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_i;
        end
    end

    assign tick_o = en_q && (cnt_q == '0);

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver with parity/framing/overrun/break reporting and a
// valid/ready output holding register.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 434,
    parameter int unsigned DATA_BITS = 8,
    parameter parity_t     PARITY    = PAR_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 overrun_o,
    output logic                 brk_o
);

    localparam logic [3:0] LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);

    logic                 rx_meta_q, rx_s_q;
    rx_state_t            state_q;
    logic [3:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q, frm_err_q, par_bit_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 perr_out_q, ferr_out_q, valid_q, overrun_q, brk_q;

    logic tick, baud_en, stop_err, frame_brk, stop_last, par_x;

    assign stop_err  = frm_err_q | ~rx_s_q;
    assign frame_brk = stop_err && (shift_q == '0) && !par_bit_q;
    assign stop_last = (bit_cnt_q == LastStop);
    assign par_x     = ^{shift_q, rx_s_q};

    // Enable drops on every exit to idle so the next start edge always sees a rising en.
    always_comb begin
        baud_en = 1'b1;
        unique case (state_q)
            StIdle:    baud_en = ~rx_s_q;
            StStart:   if (tick && rx_s_q) baud_en = 1'b0;
            StStop:    if (tick && stop_last && !frame_brk) baud_en = 1'b0;
            StBrkWait: if (rx_s_q) baud_en = 1'b0;
            default:   baud_en = 1'b1;
        endcase
    end

    uart_rx_baudgen #(
        .CLK_DIV (CLK_DIV)
    ) u_baudgen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (baud_en),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            data_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            overrun_q <= 1'b0;
            brk_q     <= 1'b0;
            if (valid_q && ready_i) valid_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (!rx_s_q) state_q <= StStart;
                end
                StStart: begin
                    if (tick) begin
                        if (rx_s_q) begin
                            state_q <= StIdle;
                        end else begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == LastData) begin
                            bit_cnt_q <= '0;
                            par_err_q <= 1'b0;
                            frm_err_q <= 1'b0;
                            par_bit_q <= 1'b0;
                            state_q   <= (PARITY == PAR_NONE) ? StStop : StParity;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                StParity: begin
                    if (tick) begin
                        par_bit_q <= rx_s_q;
                        par_err_q <= (PARITY == PAR_ODD) ? ~par_x : par_x;
                        state_q   <= StStop;
                    end
                end
                StStop: begin
                    if (tick) begin
                        if (stop_last) begin
                            if (frame_brk) begin
                                brk_q   <= 1'b1;
                                state_q <= StBrkWait;
                            end else begin
                                state_q <= StIdle;
                                if (!valid_q || ready_i) begin
                                    data_q     <= shift_q;
                                    perr_out_q <= par_err_q;
                                    ferr_out_q <= stop_err;
                                    valid_q    <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            frm_err_q <= stop_err;
                        end
                    end
                end
                StBrkWait: begin
                    if (rx_s_q) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data_o       = data_q;
    assign parity_err_o = perr_out_q;
    assign frame_err_o  = ferr_out_q;
    assign valid_o      = valid_q;
    assign overrun_o    = overrun_q;
    assign brk_o        = brk_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed scoreboard bench: three receiver configurations (8N1, 8E1, 9N2) at CLK_DIV=8.
module tb_uart_rx_framed;
    import uart_pkg::*;

    localparam int DIV = 8;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rx0, rx1, rx2;
    logic ready0, ready1, ready2;
    logic [7:0] data0, data1;
    logic [8:0] data2;
    logic perr0, ferr0, valid0, ovr0, brk0;
    logic perr1, ferr1, valid1, ovr1, brk1;
    logic perr2, ferr2, valid2, ovr2, brk2;

    int checks = 0;
    int errors = 0;
    int ovr_cnt0 = 0;
    int brk_cnt0 = 0;
    int rd_idx[3] = '{0, 0, 0};
    logic [10:0] obs0[$];
    logic [10:0] obs1[$];
    logic [10:0] obs2[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    uart_rx_framed #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u0 (
        .clk_i(clk), .rst_i(rst), .rx_i(rx0), .data_o(data0), .parity_err_o(perr0),
        .frame_err_o(ferr0), .valid_o(valid0), .ready_i(ready0), .overrun_o(ovr0), .brk_o(brk0)
    );
    uart_rx_framed #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) u1 (
        .clk_i(clk), .rst_i(rst), .rx_i(rx1), .data_o(data1), .parity_err_o(perr1),
        .frame_err_o(ferr1), .valid_o(valid1), .ready_i(ready1), .overrun_o(ovr1), .brk_o(brk1)
    );
    uart_rx_framed #(.CLK_DIV(DIV), .DATA_BITS(9), .PARITY(PAR_NONE), .STOP_BITS(2)) u2 (
        .clk_i(clk), .rst_i(rst), .rx_i(rx2), .data_o(data2), .parity_err_o(perr2),
        .frame_err_o(ferr2), .valid_o(valid2), .ready_i(ready2), .overrun_o(ovr2), .brk_o(brk2)
    );

    // Monitor: record every accepted word and count single-cycle pulses.
    always @(negedge clk) begin
        if (valid0 && ready0) obs0.push_back({perr0, ferr0, 1'b0, data0});
        if (valid1 && ready1) obs1.push_back({perr1, ferr1, 1'b0, data1});
        if (valid2 && ready2) obs2.push_back({perr2, ferr2, data2});
        if (ovr0) ovr_cnt0++;
        if (brk0) brk_cnt0++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int obs_count(input int inst);
        case (inst)
            0:       return obs0.size();
            1:       return obs1.size();
            default: return obs2.size();
        endcase
    endfunction

    function automatic logic [10:0] obs_get(input int inst, input int idx);
        case (inst)
            0:       return obs0[idx];
            1:       return obs1[idx];
            default: return obs2[idx];
        endcase
    endfunction

    task automatic set_rx(input int inst, input logic b);
        case (inst)
            0:       rx0 = b;
            1:       rx1 = b;
            default: rx2 = b;
        endcase
    endtask

    task automatic idle(input int nbits);
        repeat (nbits * DIV) @(negedge clk);
    endtask

    task automatic drive_bits(input int inst, input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(inst, v[i]);
            repeat (DIV) @(negedge clk);
        end
        set_rx(inst, 1'b1);
    endtask

    task automatic send_frame(input int inst, input logic [8:0] d, input int nbits,
                              input bit par_en, input logic pbit,
                              input logic [1:0] stops, input int nstop);
        logic [15:0] v;
        int n;
        v = '0;
        n = 1;
        for (int i = 0; i < nbits; i++) begin
            v[n] = d[i];
            n++;
        end
        if (par_en) begin
            v[n] = pbit;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            v[n] = stops[i];
            n++;
        end
        drive_bits(inst, v, n);
    endtask

    task automatic wait_word(input int inst, output logic [10:0] w, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        w  = '0;
        while (!ok && n < 400) begin
            if (obs_count(inst) > rd_idx[inst]) begin
                w = obs_get(inst, rd_idx[inst]);
                rd_idx[inst]++;
                ok = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic check_next(input string tag);
        exp_t e;
        logic [10:0] w;
        bit ok;
        e = exp_q.pop_front();
        wait_word(e.inst, w, ok);
        check({tag, "_arrived"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, "_data"}, 32'(w[8:0]), 32'(e.data));
            check({tag, "_perr"}, 32'(w[10]), 32'(e.pe));
            check({tag, "_ferr"}, 32'(w[9]), 32'(e.fe));
        end
    endtask

    initial begin
        int cyc;
        int lat_exp;
        int base;
        rst = 1'b1;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data0), 32'd0);
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_perr", 32'(perr0), 32'd0);
        check("rst_ferr", 32'(ferr0), 32'd0);
        check("rst_overrun", 32'(ovr0), 32'd0);
        check("rst_brk", 32'(brk0), 32'd0);
        rst = 1'b0;
        idle(1);

        // 8N1 0xA5 with latency measurement
        exp_q.push_back('{0, 9'h0A5, 1'b0, 1'b0});
        lat_exp = 2 + DIV / 2 + 9 * DIV + 1;
        fork
            send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 2'b11, 1);
            begin
                cyc = 0;
                while (!valid0 && cyc < 300) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        join
        check("t1_latency", 32'(cyc >= lat_exp - 1 && cyc <= lat_exp + 1), 32'd1);
        check_next("t1");
        idle(1);
        check("t1_valid_drop", 32'(valid0), 32'd0);
        check("t1_single_word", 32'(obs0.size()), 32'(rd_idx[0]));
        check("t1_no_overrun", 32'(ovr_cnt0), 32'd0);

        // even parity: wrong parity bit, then correct one
        exp_q.push_back('{1, 9'h003, 1'b1, 1'b0});
        send_frame(1, 9'h003, 8, 1'b1, 1'b1, 2'b11, 1);
        check_next("t2_bad");
        idle(2);
        exp_q.push_back('{1, 9'h003, 1'b0, 1'b0});
        send_frame(1, 9'h003, 8, 1'b1, 1'b0, 2'b11, 1);
        check_next("t2_good");
        idle(2);

        // stop bit low then a clean frame
        base = brk_cnt0;
        exp_q.push_back('{0, 9'h041, 1'b0, 1'b1});
        send_frame(0, 9'h041, 8, 1'b0, 1'b0, 2'b10, 1);
        check_next("t3_ferr");
        idle(2);
        check("t3_no_brk", 32'(brk_cnt0 - base), 32'd0);
        exp_q.push_back('{0, 9'h042, 1'b0, 1'b0});
        send_frame(0, 9'h042, 8, 1'b0, 1'b0, 2'b11, 1);
        check_next("t3_clean");
        idle(2);

        // overrun: consumer stalled across two frames
        ready0 = 1'b0;
        base = ovr_cnt0;
        exp_q.push_back('{0, 9'h011, 1'b0, 1'b0});
        send_frame(0, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1);
        idle(2);
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 2'b11, 1);
        idle(2);
        check("t4_valid_held", 32'(valid0), 32'd1);
        check("t4_data_held", 32'(data0), 32'h11);
        check("t4_overrun_once", 32'(ovr_cnt0 - base), 32'd1);
        ready0 = 1'b1;
        check_next("t4_word");
        repeat (2) @(negedge clk);
        check("t4_valid_drop", 32'(valid0), 32'd0);
        idle(12);
        check("t4_no_second", 32'(obs0.size()), 32'(rd_idx[0]));

        // short glitch is rejected
        rx0 = 1'b0;
        repeat (3) @(negedge clk);
        rx0 = 1'b1;
        idle(3);
        check("t5_glitch_idle", 32'(u0.state_q), 32'(StIdle));
        check("t5_glitch_no_word", 32'(obs0.size()), 32'(rd_idx[0]));

        // line break
        base = brk_cnt0;
        rx0 = 1'b0;
        idle(20);
        check("t5_brk_once", 32'(brk_cnt0 - base), 32'd1);
        check("t5_brk_no_word", 32'(obs0.size()), 32'(rd_idx[0]));
        check("t5_brk_wait", 32'(u0.state_q), 32'(StBrkWait));
        rx0 = 1'b1;
        idle(2);
        check("t5_brk_release", 32'(u0.state_q), 32'(StIdle));
        exp_q.push_back('{0, 9'h05A, 1'b0, 1'b0});
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 2'b11, 1);
        check_next("t5_after_brk");
        idle(2);

        // reset in the middle of the data bits of 0x7E
        drive_bits(0, 16'h000C, 4);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rst_data", 32'(data0), 32'd0);
        check("t6_rst_valid", 32'(valid0), 32'd0);
        check("t6_rst_ferr", 32'(ferr0), 32'd0);
        check("t6_rst_state", 32'(u0.state_q), 32'(StIdle));
        rst = 1'b0;
        idle(12);
        check("t6_discarded", 32'(obs0.size()), 32'(rd_idx[0]));

        // 9 data bits, two stop bits
        exp_q.push_back('{2, 9'h1FF, 1'b0, 1'b0});
        send_frame(2, 9'h1FF, 9, 1'b0, 1'b0, 2'b11, 2);
        check_next("t6_9b_clean");
        idle(2);
        exp_q.push_back('{2, 9'h1FF, 1'b0, 1'b1});
        send_frame(2, 9'h1FF, 9, 1'b0, 1'b0, 2'b01, 2);
        check_next("t6_9b_stop2_low");
        idle(2);
        exp_q.push_back('{2, 9'h0AA, 1'b0, 1'b1});
        send_frame(2, 9'h0AA, 9, 1'b0, 1'b0, 2'b10, 2);
        check_next("t6_9b_stop1_low");
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

endmodule
